// File: rtl/tx_fifo_ctrl.sv
// tx_fifo_ctrl: transmit-side byte FIFO and launch controller for the APB-UART.
// Bytes written from the APB side are queued in a circular buffer and handed
// one at a time to the UART transmitter. The next byte is launched only after
// the transmitter has acknowledged (tx_active) and then finished (tx_done
// rising edge) the current one.
//
// Ports:
//   clock, reset         system clock, asynchronous active-high reset
//   wr_en, wr_data       push a byte (dropped and flagged as overrun when full)
//   tx_enable            allows new launches; pushes are unaffected
//   clr_err              clears the sticky overrun / timeout_err flags
//   tx_active, tx_done   transmitter status, asynchronous to clock
//   tx_send, tx_data     launch strobe and byte to the transmitter
//   full, empty, count   registered occupancy
//   tx_busy              controller is not idle
//   overrun, timeout_err sticky error flags
module tx_fifo_ctrl #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ACK_TIMEOUT = 4095
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     tx_enable,
  input  logic                     clr_err,
  input  logic                     tx_active,
  input  logic                     tx_done,
  output logic                     tx_send,
  output logic [7:0]               tx_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     tx_busy,
  output logic                     overrun,
  output logic                     timeout_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_ACT,
    WAIT_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [AW:0]     count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            send_q, send_d;
  logic [7:0]      data_q, data_d;
  logic            overrun_q, overrun_d;
  logic            timeout_q, timeout_d;

  logic            act_m_q, act_s_q;
  logic            done_m_q, done_s_q, done_q;

  logic            push, pop, done_rise, timeout_hit;

  always_comb begin
    state_d     = state_q;
    rptr_d      = rptr_q;
    send_d      = send_q;
    data_d      = data_q;
    tmr_d       = tmr_q;
    timeout_hit = 1'b0;

    push      = wr_en && !full_q;
    pop       = (state_q == LOAD);
    done_rise = done_s_q && !done_q;
    wptr_d    = push ? wptr_q + 1'b1 : wptr_q;

    unique case (state_q)
      IDLE: begin
        if (tx_enable && !empty_q) begin
          state_d = LOAD;
          // Capture on entry so tx_data is already valid during LOAD and
          // stays stable until the controller is back in IDLE.
          data_d  = mem_q[rptr_q];
        end
      end
      LOAD: begin
        rptr_d  = rptr_q + 1'b1;
        send_d  = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        tmr_d   = '0;
        state_d = WAIT_ACT;
      end
      WAIT_ACT: begin
        if (act_s_q) begin
          send_d  = 1'b0;
          state_d = WAIT_DONE;
        end else if (tmr_q == TMR_LAST) begin
          // Byte is abandoned; it has already left the FIFO.
          send_d      = 1'b0;
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (done_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);

    // Setting has priority over clearing.
    overrun_d = (wr_en && full_q) ? 1'b1 : (clr_err ? 1'b0 : overrun_q);
    timeout_d = timeout_hit       ? 1'b1 : (clr_err ? 1'b0 : timeout_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      tmr_q     <= '0;
      send_q    <= 1'b0;
      data_q    <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      act_m_q   <= 1'b0;
      act_s_q   <= 1'b0;
      done_m_q  <= 1'b0;
      done_s_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      tmr_q     <= tmr_d;
      send_q    <= send_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
      act_m_q   <= tx_active;
      act_s_q   <= act_m_q;
      done_m_q  <= tx_done;
      done_s_q  <= done_m_q;
      done_q    <= done_s_q;
    end
  end

  // Storage carries no reset; stale contents are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  assign tx_send     = send_q;
  assign tx_data     = data_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign count       = count_q;
  assign tx_busy     = (state_q != IDLE);
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_tx_fifo_ctrl.sv
// Testbench for tx_fifo_ctrl: directed scenarios plus randomized fill/drain
// traffic checked against a queue-based model of the byte stream.
module tb_tx_fifo_ctrl;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ACK_TO = 20;

  logic       clock = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       tx_enable;
  logic       clr_err;
  logic       tx_active;
  logic       tx_done;
  logic       tx_send;
  logic [7:0] tx_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       tx_busy;
  logic       overrun;
  logic       timeout_err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Bytes accepted but not yet launched, in order.
  logic [7:0] exp_q [$];

  // Transmitter: either a behavioural model or manual drive from the test.
  logic        man_mode = 1'b1;
  logic        man_act  = 1'b0;
  logic        man_done = 1'b0;
  logic        m_act    = 1'b0;
  logic        m_done   = 1'b0;
  logic        ack_en   = 1'b1;
  int unsigned act_dly  = 3;
  int unsigned done_dly = 10;

  assign tx_active = man_mode ? man_act  : m_act;
  assign tx_done   = man_mode ? man_done : m_done;

  always #5 clock = ~clock;

  tx_fifo_ctrl #(
    .DEPTH       (DEPTH),
    .ACK_TIMEOUT (ACK_TO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .tx_enable   (tx_enable),
    .clr_err     (clr_err),
    .tx_active   (tx_active),
    .tx_done     (tx_done),
    .tx_send     (tx_send),
    .tx_data     (tx_data),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .tx_busy     (tx_busy),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every launch must carry the oldest unlaunched byte.
  logic send_prev = 1'b0;
  always @(negedge clock) begin
    if (reset === 1'b0 && tx_send === 1'b1 && send_prev !== 1'b1) begin
      if (exp_q.size() == 0) check("launch_unexpected", exp_q.size(), 1);
      else                   check("launch_data", tx_data, exp_q.pop_front());
    end
    send_prev = tx_send;
  end

  // Transmitter model: acknowledge after act_dly, finish after done_dly.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (!man_mode && ack_en && tx_send === 1'b1 && reset === 1'b0) begin
        repeat (act_dly) @(posedge clock);
        #1 m_act = 1'b1; m_done = 1'b0;
        repeat (done_dly) @(posedge clock);
        #1 m_act = 1'b0; m_done = 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic push_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    exp_q.push_back(b);
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  task automatic wait_send(input string tag);
    int unsigned n = 0;
    while (tx_send !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check(tag, tx_send, 1);
  endtask

  task automatic wait_drain(input string tag, input int unsigned budget);
    int unsigned n = 0;
    while (!(tx_busy === 1'b0 && empty === 1'b1 && exp_q.size() == 0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_busy"}, tx_busy, 0);
    check({tag, "_left"}, exp_q.size(), 0);
    check({tag, "_count"}, count, 0);
  endtask

  logic        we, cl, ov_m;
  logic [7:0]  d;
  int unsigned n;

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = '0; tx_enable = 1'b0; clr_err = 1'b0;
    ov_m = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("rst_tx_send", tx_send, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_count", count, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_timeout", timeout_err, 0);
    reset = 1'b0;
    @(negedge clock);

    // Single byte: launch latency and full completion.
    man_mode = 1'b0; act_dly = 10; done_dly = 90;
    tx_enable = 1'b1;
    push_byte(8'hA5);
    check("single_empty", empty, 0);
    check("single_count", count, 1);
    @(negedge clock);
    check("single_load_busy", tx_busy, 1);
    check("single_load_data", tx_data, 8'hA5);
    @(negedge clock);
    check("single_send", tx_send, 1);
    check("single_send_data", tx_data, 8'hA5);
    wait_drain("single", 400);
    check("single_send_low", tx_send, 0);

    // Push in the LOAD cycle: count holds and the byte goes out fourth.
    tx_enable = 1'b0; act_dly = 2; done_dly = 6;
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    check("simul_pre_count", count, 3);
    tx_enable = 1'b1;
    @(negedge clock);
    check("simul_load", tx_busy, 1);
    push_byte(8'h44);
    check("simul_count", count, 3);
    wait_drain("simul", 500);

    // Random fill with launches disabled: occupancy and overrun vs model.
    tx_enable = 1'b0;
    for (int i = 0; i < 60; i++) begin
      we = ($urandom_range(0, 3) != 0);
      cl = ($urandom_range(0, 7) == 0);
      d  = 8'($urandom);
      wr_en = we; wr_data = d; clr_err = cl;
      if (we && exp_q.size() == DEPTH) ov_m = 1'b1;
      else if (cl)                     ov_m = 1'b0;
      if (we && exp_q.size() < DEPTH) exp_q.push_back(d);
      @(negedge clock);
      check("fill_count", count, exp_q.size());
      check("fill_full", full, (exp_q.size() == DEPTH));
      check("fill_empty", empty, (exp_q.size() == 0));
      check("fill_overrun", overrun, ov_m);
    end
    wr_en = 1'b0;
    clr_err = 1'b1;
    @(negedge clock);
    clr_err = 1'b0;
    check("fill_clr", overrun, 0);

    // Random drain with concurrent pushes and random transmitter delays.
    tx_enable = 1'b1;
    for (int i = 0; i < 150; i++) begin
      act_dly  = $urandom_range(1, 6);
      done_dly = $urandom_range(4, 20);
      if (exp_q.size() < DEPTH - 1 && $urandom_range(0, 3) == 0) begin
        wr_en   = 1'b1;
        wr_data = 8'($urandom);
        exp_q.push_back(wr_data);
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clock);
    end
    wr_en = 1'b0;
    wait_drain("drain", 3000);

    // Acknowledge timeout: first byte abandoned, second goes out normally.
    tx_enable = 1'b0; ack_en = 1'b0; act_dly = 3; done_dly = 8;
    push_byte(8'hBB);
    push_byte(8'hCC);
    tx_enable = 1'b1;
    wait_send("to_send");
    n = 0;
    while (tx_send === 1'b1 && n < 100) begin
      n++;
      @(negedge clock);
    end
    check("to_len", n, ACK_TO + 1);
    check("to_err_set", timeout_err, 1);
    ack_en = 1'b1;
    wait_drain("to_next", 300);
    check("to_err_sticky", timeout_err, 1);
    clr_err = 1'b1;
    @(negedge clock);
    clr_err = 1'b0;
    check("to_err_clr", timeout_err, 0);

    // Stale done: a level-high tx_done must not complete the byte.
    man_mode = 1'b1; man_act = 1'b0; man_done = 1'b1;
    repeat (4) @(negedge clock);
    push_byte(8'h5A);
    wait_send("stale_send");
    man_act = 1'b1;
    repeat (30) @(negedge clock);
    check("stale_send_low", tx_send, 0);
    check("stale_busy", tx_busy, 1);
    man_done = 1'b0;
    repeat (3) @(negedge clock);
    man_act = 1'b0; man_done = 1'b1;
    wait_drain("stale_done", 50);

    // Reset while waiting for done with five bytes still queued.
    tx_enable = 1'b0; man_done = 1'b0;
    for (int i = 0; i < 6; i++) push_byte(8'(8'h60 + i));
    tx_enable = 1'b1;
    wait_send("rm_send");
    man_act = 1'b1;
    n = 0;
    while (tx_send === 1'b1 && n < 20) begin
      n++;
      @(negedge clock);
    end
    check("rm_count", count, 5);
    check("rm_busy", tx_busy, 1);
    #2 reset = 1'b1;
    #1;
    check("rm_send_async", tx_send, 0);
    check("rm_count_async", count, 0);
    check("rm_empty_async", empty, 1);
    exp_q.delete();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0; man_act = 1'b0; tx_enable = 1'b0;
    @(negedge clock);
    check("rm_idle", tx_busy, 0);
    check("rm_count_after", count, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
